// File: rtl/fib_stream_checker.sv
// In-system monitor for a Fibonacci term stream: locks on the 0,1 seed, checks the
// recurrence on every later term, counts terms and sequences, and flags mismatches.
module fib_stream_checker #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
    input  logic          clr,
    output logic          locked,
    output logic [CW-1:0] term_cnt,
    output logic [CW-1:0] seq_cnt,
    output logic [W-1:0]  last_term,
    output logic          seq_done,
    output logic          seq_full,
    output logic          mismatch,
    output logic          err,
    output logic [CW-1:0] err_term
);

    typedef enum logic [1:0] {
        SEEK_ZERO,
        EXP_ONE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  prev1, prev2;
    logic [W:0]    exp_sum;
    logic          din_zero, din_one, din_match;

    logic          ev_seed_zero, ev_seed_one, ev_hold_zero;
    logic          ev_accept, ev_restart, ev_bad;

    logic [CW-1:0] term_cnt_next;
    logic [W-1:0]  last_term_next;
    logic [W-1:0]  prev1_next, prev2_next;
    logic [CW-1:0] term_cnt_inc, seq_cnt_inc;

    // Carry bit marks that the true next term no longer fits in W bits.
    assign exp_sum   = {1'b0, prev1} + {1'b0, prev2};
    assign din_zero  = (din == '0);
    assign din_one   = (din == W'(1));
    assign din_match = (din == exp_sum[W-1:0]) && !exp_sum[W];

    assign term_cnt_inc = (term_cnt == '1) ? term_cnt : term_cnt + CW'(1);
    assign seq_cnt_inc  = (seq_cnt  == '1) ? seq_cnt  : seq_cnt  + CW'(1);

    assign locked = (state == RUN);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEEK_ZERO;
        end else begin
            state <= state_next;
        end
    end

    // Event decode and next-state logic
    always_comb begin
        ev_seed_zero = 1'b0;
        ev_seed_one  = 1'b0;
        ev_hold_zero = 1'b0;
        ev_accept    = 1'b0;
        ev_restart   = 1'b0;
        ev_bad       = 1'b0;
        state_next   = state;
        if (din_valid) begin
            unique case (state)
                SEEK_ZERO: begin
                    if (din_zero) begin
                        ev_seed_zero = 1'b1;
                        state_next   = EXP_ONE;
                    end
                end
                EXP_ONE: begin
                    if (din_one) begin
                        ev_seed_one = 1'b1;
                        state_next  = RUN;
                    end else if (din_zero) begin
                        ev_hold_zero = 1'b1;
                    end else begin
                        ev_bad     = 1'b1;
                        state_next = SEEK_ZERO;
                    end
                end
                RUN: begin
                    // prev1 >= 1 in RUN, so a zero can never also be an accept.
                    if (din_match) begin
                        ev_accept = 1'b1;
                    end else if (din_zero) begin
                        ev_restart = 1'b1;
                        state_next = EXP_ONE;
                    end else begin
                        ev_bad     = 1'b1;
                        state_next = SEEK_ZERO;
                    end
                end
                default: state_next = SEEK_ZERO;
            endcase
        end
    end

    // Next values of the tracking datapath
    always_comb begin
        term_cnt_next  = term_cnt;
        last_term_next = last_term;
        prev1_next     = prev1;
        prev2_next     = prev2;
        if (ev_seed_zero || ev_hold_zero || ev_restart) begin
            term_cnt_next  = CW'(1);
            last_term_next = '0;
        end else if (ev_seed_one) begin
            term_cnt_next  = CW'(2);
            last_term_next = W'(1);
            prev1_next     = W'(1);
            prev2_next     = '0;
        end else if (ev_accept) begin
            term_cnt_next  = term_cnt_inc;
            last_term_next = din;
            prev1_next     = din;
            prev2_next     = prev1;
        end else if (ev_bad) begin
            term_cnt_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev1     <= '0;
            prev2     <= '0;
            last_term <= '0;
            term_cnt  <= '0;
        end else begin
            prev1     <= prev1_next;
            prev2     <= prev2_next;
            last_term <= last_term_next;
            term_cnt  <= term_cnt_next;
        end
    end

    // Pulses and statistics; a coincident event overrides clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_done <= 1'b0;
            seq_full <= 1'b0;
            mismatch <= 1'b0;
            seq_cnt  <= '0;
            err      <= 1'b0;
            err_term <= '0;
        end else begin
            seq_done <= ev_restart;
            seq_full <= ev_restart && exp_sum[W];
            mismatch <= ev_bad;

            if (ev_restart) begin
                seq_cnt <= clr ? CW'(1) : seq_cnt_inc;
            end else if (clr) begin
                seq_cnt <= '0;
            end

            if (ev_bad) begin
                err <= 1'b1;
                if (!err || clr) begin
                    err_term <= term_cnt;
                end
            end else if (clr) begin
                err      <= 1'b0;
                err_term <= '0;
            end
        end
    end

endmodule
